// File: rtl/sr_pkg.sv
// ============================================================================
// Module      : sr_pkg
// Description : Shared types and constants for the paced shift-register core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2
   } sr_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef struct packed {
      logic dir;
      logic din;
   } sr_cmd_t;

endpackage

`default_nettype wire

// File: rtl/sr_cmd_fifo.sv
// ============================================================================
// Module      : sr_cmd_fifo
// Description : Synchronous command FIFO; a push on a full queue is accepted
//               only when a pop frees the head slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cmd_fifo
   import sr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  sr_cmd_t                i_data,
   input  logic                   i_pop,
   output sr_cmd_t                o_data,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   sr_cmd_t     r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   logic w_full;
   logic w_empty;
   logic w_pop_ok;
   logic w_push_ok;

   // Extra wrap bit makes the pointer difference the occupancy directly.
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign w_full    = (o_count == (AW + 1)'(DEPTH));
   assign w_empty   = (o_count == '0);
   assign w_pop_ok  = i_pop & ~w_empty;
   assign w_push_ok = i_push & (~w_full | w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sr_shift_core.sv
// ============================================================================
// Module      : sr_shift_core
// Description : Bidirectional shift register fed by queued, edge-triggered
//               commands and applied at a programmable pace.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_shift_core
   import sr_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV        = 1
) (
   input  logic             S_AXI_ACLK,
   input  logic             S_AXI_ARESET,
   input  logic             dir,
   input  logic             din,
   input  logic             en,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             ovf,
   output logic [15:0]      shift_cnt
);

   localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LOAD = c_DIV_W'(DIV - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

   sr_state_t          r_state;
   sr_state_t          w_state_nxt;
   sr_cmd_t            r_cmd;
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [WIDTH-1:0]   r_q;
   logic [15:0]        r_shift_cnt;
   logic               r_ovf;
   logic               r_en_d;

   sr_cmd_t            w_cmd_in;
   sr_cmd_t            w_fifo_head;
   logic [c_CNT_W-1:0] w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_rise;
   logic               w_pop;
   logic               w_dec;
   logic               w_shift;
   logic               w_drop;

   assign w_rise       = en & ~r_en_d;
   assign w_cmd_in     = {dir, din};
   assign w_fifo_full  = (w_fifo_count == c_FULL_CNT);
   assign w_fifo_empty = (w_fifo_count == '0);
   assign w_drop       = w_rise & w_fifo_full & ~w_pop;

   sr_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (S_AXI_ACLK),
      .rst     (S_AXI_ARESET),
      .i_push  (w_rise),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_head),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_dec       = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_div_cnt == '0) begin
               w_state_nxt = ST_SHIFT;
            end else begin
               w_dec = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_shift     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // en_d resets high so a level already present at reset release is ignored.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_en_d      <= 1'b1;
         r_cmd       <= '0;
         r_div_cnt   <= '0;
         r_q         <= '0;
         r_shift_cnt <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_en_d <= en;
         if (w_pop) begin
            r_cmd     <= w_fifo_head;
            r_div_cnt <= c_DIV_LOAD;
         end else if (w_dec) begin
            r_div_cnt <= r_div_cnt - 1'b1;
         end
         if (w_shift) begin
            case (r_cmd.dir)
               DIR_LEFT:  r_q <= {r_q[WIDTH-2:0], r_cmd.din};
               DIR_RIGHT: r_q <= {r_cmd.din, r_q[WIDTH-1:1]};
            endcase
            r_shift_cnt <= r_shift_cnt + 16'd1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign q         = r_q;
   assign ovf       = r_ovf;
   assign shift_cnt = r_shift_cnt;
   assign busy      = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule

`default_nettype wire

// File: doc/sr_shift_core.md
# sr_shift_core

Bidirectional shift-register core that sits directly downstream of the AXI-Lite shift-register adapter. It consumes the adapter's `dir`, `din` and `en` strobes and returns the 4-bit parallel state `q` to the adapter's STATE register. Each rising edge of `en` is queued as one shift command, and commands are applied at a programmable pace. The pacing lets a slow physical consumer (LEDs, external latch) observe every step, and the queue prevents register writes that arrive during a shift from being lost silently.

## Interface
Parameters:
- `WIDTH`, 4: shift-register length in bits, ≥2.
- `FIFO_DEPTH`, 4: command queue entries, power of two, ≥2.
- `DIV`, 1: pacing, in clock cycles spent in the WAIT state per shift, ≥1.

Ports:
- `S_AXI_ACLK`, in, 1: the only clock.
- `S_AXI_ARESET`, in, 1: synchronous, active-high reset.
- `dir`, in, 1: shift direction; 0 = left (toward MSB), 1 = right.
- `din`, in, 1: serial bit shifted in.
- `en`, in, 1: command strobe; a rising edge enqueues one command.
- `clr_ovf`, in, 1: clears `ovf`.
- `q`, out, WIDTH: parallel register contents.
- `busy`, out, 1: a command is in flight or queued.
- `ovf`, out, 1: sticky flag; a command was dropped because the queue was full.
- `shift_cnt`, out, 16: number of shifts performed, wrapping.

## Operation
- Edge detect:
  - `en_d` is a register of `en`.
  - `rise = en & ~en_d`.
  - `en` held high for any number of cycles produces exactly one command.
- On `rise`, `{dir,din}` sampled in that same cycle are pushed into the FIFO.
- Full FIFO:
  - If the FIFO is full (registered count == FIFO_DEPTH) and no pop happens that cycle, the command is dropped and `ovf` is set to 1.
  - A push and a pop in the same cycle on a full FIFO: the push is accepted and the count is unchanged.
- `ovf` priority: set beats `clr_ovf` in the same cycle.
- FSM, states IDLE / WAIT / SHIFT:
  - IDLE: if the FIFO is non-empty, pop the head into `cmd_r`, load `div_cnt = DIV-1`, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if `div_cnt == 0` go to SHIFT, else decrement `div_cnt`.
  - SHIFT: apply `cmd_r`, increment `shift_cnt`, go to IDLE.
- Shift arithmetic:
  - Left: `q <= {q[WIDTH-2:0], din}`.
  - Right: `q <= {din, q[WIDTH-1:1]}`.
  - `shift_cnt` wraps from 16'hFFFF to 0.
- `busy = (state != IDLE) | ~fifo_empty`.
- Reset values: `q` = 0, `shift_cnt` = 0, `ovf` = 0, `busy` = 0, FIFO empty, state IDLE, `en_d` = 1.
  - `en_d` resets to 1 so that `en` high while reset is released creates no command.
- Reset mid-operation: queued and in-flight commands are discarded, and no shift occurs after reset deasserts.

## Timing
- Edge E0 samples `rise`, and the command is pushed at E0.
- E1: IDLE pops the command.
- E(1+DIV): WAIT sees `div_cnt == 0`.
- E(2+DIV): `q` and `shift_cnt` update.
- Latency from the `rise` edge to `q` updating is DIV+2 cycles.
- Throughput: one shift per DIV+2 cycles. IDLE always costs one cycle, with no bypass.
- `busy` rises at E0+1 (registered FIFO count). It falls at the edge where the last SHIFT completes, provided the FIFO is empty.
- All outputs are registered except `busy`, which is a combinational function of registers only.

## Structure
- Package `sr_pkg`:
  - FSM state encoding (IDLE/WAIT/SHIFT).
  - `DIR_LEFT = 0`, `DIR_RIGHT = 1`.
  - Command type `{dir, din}`, 2 bits.
- Sub-module `sr_cmd_fifo`:
  - Synchronous FIFO, 2 bits wide, `FIFO_DEPTH` deep.
  - Pointers carry an extra wrap bit; a count output provides full/empty.
  - Push/pop handling follows the rules above.
- Top level holds the edge detector, FSM, divider, shift register, counter and `ovf`.

## Test plan
- Single left shift: DIV=1, `q` = 0000, one `en` pulse with dir=0, din=1. Required: `q` = 0001 exactly 3 cycles after the `rise` edge; `shift_cnt` = 1; `busy` low afterwards.
- Level hold: `en` held high for 5 cycles with dir=0, din=1. Required: exactly one shift, `q` = 0001, `shift_cnt` = 1.
- Right sequence: dir=1, din = 1, 0, 1, 1 on four spaced pulses, starting from 0000. Required: `q` = 1000 → 0100 → 1010 → 1101.
- Overflow: DIV=8, FIFO_DEPTH=4, six `en` pulses at a 2-cycle period. Required:
  - The 6th command, at E10, is dropped and `ovf` = 1.
  - 5 shifts occur in total and `shift_cnt` = 5.
  - `clr_ovf` then returns `ovf` to 0.
- Reset mid-WAIT: DIV=8 with 3 commands queued; assert `S_AXI_ARESET` for 1 cycle. Required:
  - `q` = 0, `busy` = 0 and `shift_cnt` = 0 on the next cycle.
  - No shifts afterwards, with `en` held high through reset release.
- Same-cycle clear/set: `clr_ovf` asserted in the same cycle as an overflowing push. Required: `ovf` = 1.
